// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                             |
// | Byte/half/word load-store initiator with sub-word RMW and split accesses.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ACC0 = 2'd1;
  localparam logic [1:0] c_ACC1 = 2'd2;
  localparam logic [1:0] c_RESP = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic [31:0] r_word1;

  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [7:0]  w_lanes;
  logic [63:0] w_wsh;
  logic        w_cross;
  logic [31:0] w_a0;
  logic [31:0] w_wd0;
  logic [31:0] w_wd1;
  logic [31:0] w_ld;
  logic [31:0] w_ext;

  assign w_off = r_addr[1:0];
  assign w_a0  = {r_addr[31:2], 2'b00};

  always_comb begin
    case (r_size)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  // Lane enables and store data across the two-word window {word1, word0}
  assign w_lanes = {4'b0000, w_mask} << w_off;
  assign w_wsh   = {32'd0, r_wdata} << {w_off, 3'b000};
  assign w_cross = |w_lanes[7:4];

  always_comb begin
    w_wd0 = mem_RD;
    w_wd1 = mem_RD;
    for (int k = 0; k < 4; k++) begin
      if (w_lanes[k])     w_wd0[8*k +: 8] = w_wsh[8*k +: 8];
      if (w_lanes[k + 4]) w_wd1[8*k +: 8] = w_wsh[32 + 8*k +: 8];
    end
  end

  always_comb begin
    case (w_off)
      2'd0:    w_ld = r_word0;
      2'd1:    w_ld = {r_word1[7:0],  r_word0[31:8]};
      2'd2:    w_ld = {r_word1[15:0], r_word0[31:16]};
      default: w_ld = {r_word1[23:0], r_word0[31:24]};
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00:   w_ext = {{24{~r_unsigned & w_ld[7]}},  w_ld[7:0]};
      2'b01:   w_ext = {{16{~r_unsigned & w_ld[15]}}, w_ld[15:0]};
      default: w_ext = w_ld;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (req_valid) w_next = c_ACC0;
      c_ACC0:  w_next = w_cross ? c_ACC1 : c_RESP;
      c_ACC1:  w_next = c_RESP;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_word0    <= 32'd0;
      r_word1    <= 32'd0;
    end else begin
      if (r_state == c_IDLE && req_valid) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
      if (r_state == c_ACC0 && !r_we) r_word0 <= mem_RD;
      if (r_state == c_ACC1 && !r_we) r_word1 <= mem_RD;
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    mem_A      = 32'd0;
    mem_WD     = 32'd0;
    mem_WE     = 1'b0;
    case (r_state)
      c_IDLE: req_ready = 1'b1;
      c_ACC0: begin
        mem_A = w_a0;
        if (r_we) begin
          mem_WE = 1'b1;
          mem_WD = w_wd0;
        end
      end
      c_ACC1: begin
        mem_A = w_a0 + 32'd4;
        if (r_we) begin
          mem_WE = 1'b1;
          mem_WD = w_wd1;
        end
      end
      default: begin
        resp_valid = 1'b1;
        if (!r_we) resp_rdata = w_ext;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit                                                          |
// | Directed vector bench for mem_access_unit with a four-word memory model.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4];
  logic        preload = 1'b0;

  always #5 clk = ~clk;

  // Word 3 stands in for 0xFFFFFFFC so the wrap case reads distinct data
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h8CDEFAB7;
      mem[1] <= 32'h11223344;
      mem[2] <= 32'h00000000;
      mem[3] <= 32'hA0000000;
    end else if (mem_WE) begin
      mem[mem_A[3:2]] <= mem_WD;
    end
  end

  assign mem_RD = mem[mem_A[3:2]];

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_A        (mem_A),
    .mem_WD       (mem_WD),
    .mem_WE       (mem_WE),
    .mem_RD       (mem_RD)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] w0;
    logic [31:0] w1;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk); #1;
    // Junk on the request bus must not disturb the latched transaction
    req_valid    = 1'b0;
    req_we       = ~v.we;
    req_size     = ~v.size;
    req_unsigned = ~v.uns;
    req_addr     = 32'hDEADBEE1;
    req_wdata    = 32'h5A5A5A5A;
  endtask

  task automatic do_req(input vec_t v, output logic [31:0] rdata, output int lat,
                        output int nwr, output logic [31:0] a0, output logic [31:0] a1,
                        output logic rdy_busy);
    issue(v);
    lat = 0; nwr = 0; a0 = 32'd0; a1 = 32'd0; rdy_busy = 1'b0;
    while (!resp_valid && lat < 6) begin
      if (lat == 0) a0 = mem_A;
      if (lat == 1) a1 = mem_A;
      if (mem_WE) nwr++;
      if (req_ready) rdy_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
  endtask

  initial begin
    logic [31:0] rdata, a0, a1;
    int          lat, nwr;
    logic        rdy_busy;
    vec_t        v;

    //            we    size   uns   addr           wdata          rdata          a0             a1             w0             w1           lat nwr
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h00000000, 32'h0,        32'h8CDEFAB7, 32'h00000000, 32'h0,        32'h8CDEFAB7, 32'h11223344, 1, 0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h00000001, 32'h0,        32'hFFFFFFFA, 32'h00000000, 32'h0,        32'h8CDEFAB7, 32'h11223344, 1, 0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h00000001, 32'h0,        32'h000000FA, 32'h00000000, 32'h0,        32'h8CDEFAB7, 32'h11223344, 1, 0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h00000002, 32'h0,        32'h00008CDE, 32'h00000000, 32'h0,        32'h8CDEFAB7, 32'h11223344, 1, 0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h00000002, 32'h0,        32'hFFFF8CDE, 32'h00000000, 32'h0,        32'h8CDEFAB7, 32'h11223344, 1, 0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h00000002, 32'h0,        32'h33448CDE, 32'h00000000, 32'h00000004, 32'h8CDEFAB7, 32'h11223344, 2, 0};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h00000003, 32'h0000BEEF, 32'h00000000, 32'h00000000, 32'h00000004, 32'hEFDEFAB7, 32'h112233BE, 2, 2};
    vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h00000006, 32'h12345655, 32'h00000000, 32'h00000004, 32'h0,        32'h8CDEFAB7, 32'h11553344, 1, 1};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'hFFFFB7A0, 32'hFFFFFFFC, 32'h00000000, 32'h8CDEFAB7, 32'h11223344, 2, 0};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 32'h00000007, 32'h0,        32'h00000011, 32'h00000004, 32'h0,        32'h8CDEFAB7, 32'h11223344, 1, 0};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h00000001, 32'hA1B2C3D4, 32'h00000000, 32'h00000000, 32'h00000004, 32'hB2C3D4B7, 32'h112233A1, 2, 2};
    vecs[11] = '{1'b0, 2'd3, 1'b1, 32'h00000000, 32'h0,        32'h8CDEFAB7, 32'h00000000, 32'h0,        32'h8CDEFAB7, 32'h11223344, 1, 0};

    // Reset state while rst is held low
    #2;
    check("rst req_ready",  {31'd0, req_ready},  32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_rdata", resp_rdata,           32'd0);
    check("rst mem_WE",     {31'd0, mem_WE},     32'd0);
    check("rst mem_A",      mem_A,                32'd0);
    check("rst mem_WD",     mem_WD,               32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_preload();
      do_req(vecs[i], rdata, lat, nwr, a0, a1, rdy_busy);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d rdata", i), rdata, vecs[i].rdata);
      check($sformatf("v%0d writes", i), nwr, vecs[i].nwr);
      check($sformatf("v%0d mem_A0", i), a0, vecs[i].a0);
      if (vecs[i].lat == 2) check($sformatf("v%0d mem_A1", i), a1, vecs[i].a1);
      check($sformatf("v%0d busy ready", i), {31'd0, rdy_busy}, 32'd0);
      check($sformatf("v%0d word0", i), mem[0], vecs[i].w0);
      check($sformatf("v%0d word1", i), mem[1], vecs[i].w1);
      @(posedge clk); #1;
      check($sformatf("v%0d resp pulse", i), {31'd0, resp_valid}, 32'd0);
      check($sformatf("v%0d ready after", i), {31'd0, req_ready}, 32'd1);
    end

    // Reset during ACC1 of a crossing store: first half stays, second half never written
    do_preload();
    v = vecs[6];
    issue(v);
    check("mid ACC0 mem_WE", {31'd0, mem_WE}, 32'd1);
    @(posedge clk); #1;
    check("mid ACC1 mem_WE", {31'd0, mem_WE}, 32'd1);
    check("mid ACC1 mem_A",  mem_A, 32'h00000004);
    rst = 1'b0;
    #1;
    check("mid rst mem_WE",     {31'd0, mem_WE},     32'd0);
    check("mid rst mem_A",      mem_A,                32'd0);
    check("mid rst req_ready",  {31'd0, req_ready},  32'd1);
    check("mid rst resp_valid", {31'd0, resp_valid}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("mid hold resp_valid", {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid word0", mem[0], 32'hEFDEFAB7);
    check("mid word1", mem[1], 32'h11223344);
    check("mid ready", {31'd0, req_ready}, 32'd1);
    check("mid no resp", {31'd0, resp_valid}, 32'd0);
    v = vecs[0];
    do_req(v, rdata, lat, nwr, a0, a1, rdy_busy);
    check("post rst latency", lat, 1);
    check("post rst rdata", rdata, 32'hEFDEFAB7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
